csr_unit: RTL and testbench

Parametrised control/status register unit for the RISC-V core. It replaces the fixed counter/fcsr file with Zicsr read-modify-write semantics (RW/RS/RC), writable machine counters with inhibit, optional hardware performance counters, FPU flag accrual and illegal-access detection. It sits beside the execute stage. It is read combinationally in the issuing cycle and committed on the following clock edge.

---
 rtl/csr_pkg.sv | 52 +++++
 rtl/csr_counter.sv | 30 +++
 rtl/csr_unit.sv | 170 +++++++++++++++++
 tb/tb_csr_unit.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/csr_pkg.sv
// Shared constants for the CSR unit: address map, op encodings, fcsr layout
// and mcountinhibit bit positions.
package csr_pkg;

    typedef enum logic [1:0] {
        OP_NONE = 2'b00,
        OP_RW   = 2'b01,
        OP_RS   = 2'b10,
        OP_RC   = 2'b11
    } csr_op_e;

    localparam logic [11:0] ADDR_FFLAGS        = 12'h001;
    localparam logic [11:0] ADDR_FRM           = 12'h002;
    localparam logic [11:0] ADDR_FCSR          = 12'h003;
    localparam logic [11:0] ADDR_MCOUNTINHIBIT = 12'h320;

    // Counter space: page B is machine (writable), page C is the read-only
    // user shadow. Bit 7 selects the high half, bits [4:0] the counter number.
    localparam logic [3:0] CNT_M_PAGE    = 4'hB;
    localparam logic [3:0] CNT_U_PAGE    = 4'hC;
    localparam int         CNT_HI_BIT    = 7;
    localparam logic [4:0] CNT_CYCLE     = 5'd0;
    localparam logic [4:0] CNT_INSTRET   = 5'd2;
    localparam int         CNT_HPM_FIRST = 3;

    localparam int FFLAGS_LSB = 0;
    localparam int FFLAGS_MSB = 4;
    localparam int FRM_LSB    = 5;
    localparam int FRM_MSB    = 7;

    localparam int INH_CY   = 0;
    localparam int INH_IR   = 2;
    localparam int INH_HPM0 = 3;

    // Physical counter slot: 0 = cycle, 1 = instret, 2.. = hpm3..
    function automatic logic [3:0] cnt_slot(input logic [4:0] num);
        if (num == CNT_CYCLE)
            return 4'd0;
        else if (num == CNT_INSTRET)
            return 4'd1;
        else
            return 4'(num - 5'd1);
    endfunction

    // Writable mcountinhibit bits: CY, IR and one per implemented hpm counter.
    function automatic logic [31:0] inh_mask(input int num_hpm);
        logic [31:0] hpm_bits;
        hpm_bits = ((32'd1 << num_hpm) - 32'd1) << INH_HPM0;
        return hpm_bits | (32'd1 << INH_CY) | (32'd1 << INH_IR);
    endfunction

endpackage

// File: rtl/csr_counter.sv
// One wide counter with independently writable 32-bit low half and upper
// half. A write to either half suppresses the increment for that cycle, so
// the untouched half holds and no carry crosses into the written half.
module csr_counter #(
    parameter int W = 64
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          inc,
    input  logic          wrLo,
    input  logic          wrHi,
    input  logic [31:0]   wdata,
    output logic [W-1:0]  value
);

    // Write beats increment; increment wraps modulo 2^W.
    always_ff @(posedge clk) begin
        if (reset) begin
            value <= '0;
        end else if (wrLo || wrHi) begin
            if (wrLo)
                value[31:0] <= wdata;
            if (wrHi)
                value[W-1:32] <= wdata[W-33:0];
        end else if (inc) begin
            value <= value + W'(1);
        end
    end

endmodule

// File: rtl/csr_unit.sv
// CSR unit: decodes the CSR address, performs RW/RS/RC read-modify-write,
// flags illegal accesses, and owns mcountinhibit, fcsr and the counter bank.
// Reads are combinational; writes commit on the next clock edge.
module csr_unit
    import csr_pkg::*;
#(
    parameter int NUM_HPM   = 4,
    parameter int COUNTER_W = 64,
    parameter int HAS_FPU   = 1
) (
    input  logic                                    clk_i,
    input  logic                                    reset_i,
    input  logic                                    csrValid_i,
    input  logic [1:0]                              csrOp_i,
    input  logic [11:0]                             csrAddr_i,
    input  logic [31:0]                             csrSrc_i,
    output logic [31:0]                             csrRData_o,
    output logic                                    csrIllegal_o,
    input  logic                                    csrInstStep_i,
    input  logic                                    fflagsValid_i,
    input  logic [4:0]                              fflags_i,
    input  logic [((NUM_HPM > 0) ? NUM_HPM : 1)-1:0] hpmEvent_i,
    output logic [2:0]                              csrFRM_o
);

    localparam int          NUM_CNT  = 2 + NUM_HPM;
    localparam logic [31:0] INH_MASK = inh_mask(NUM_HPM);

    csr_op_e               op;
    logic                  cnt_space;
    logic                  cnt_ok;
    logic                  cnt_hi;
    logic                  cnt_mpage;
    logic [4:0]            cnt_num;
    logic [3:0]            slot;
    logic                  is_fp;
    logic                  fp_ok;
    logic                  is_inh;
    logic                  do_write;
    logic                  wr_en;
    logic                  illegal;
    logic [31:0]           raw;
    logic [31:0]           wval;
    logic [COUNTER_W-1:0]  sel_cnt;
    logic [63:0]           sel_ext;
    logic [31:0]           inhibit;
    logic [7:0]            fcsr;
    logic [7:0]            fcsr_next;
    logic [NUM_CNT-1:0]    cnt_inc;
    logic [NUM_CNT-1:0]    cnt_wr_lo;
    logic [NUM_CNT-1:0]    cnt_wr_hi;
    logic [COUNTER_W-1:0]  cnt_val [NUM_CNT];

    // Address decode and legality.
    always_comb begin
        op        = csr_op_e'(csrOp_i);
        cnt_mpage = (csrAddr_i[11:8] == CNT_M_PAGE);
        cnt_space = (cnt_mpage || csrAddr_i[11:8] == CNT_U_PAGE) && (csrAddr_i[6:5] == 2'b00);
        cnt_num   = csrAddr_i[4:0];
        cnt_hi    = csrAddr_i[CNT_HI_BIT];
        cnt_ok    = cnt_space && (cnt_num == CNT_CYCLE || cnt_num == CNT_INSTRET ||
                    (int'(cnt_num) >= CNT_HPM_FIRST && int'(cnt_num) < CNT_HPM_FIRST + NUM_HPM));
        slot      = cnt_slot(cnt_num);
        is_fp     = (csrAddr_i == ADDR_FFLAGS) || (csrAddr_i == ADDR_FRM) || (csrAddr_i == ADDR_FCSR);
        fp_ok     = is_fp && (HAS_FPU != 0);
        is_inh    = (csrAddr_i == ADDR_MCOUNTINHIBIT);
        // RS/RC with a zero source is a pure read, so it may target read-only CSRs.
        do_write  = csrValid_i && (op != OP_NONE) && !((op != OP_RW) && (csrSrc_i == 32'd0));
        illegal   = csrValid_i && (!(cnt_ok || fp_ok || is_inh) ||
                    ((csrAddr_i[11:10] == 2'b11) && do_write));
        wr_en     = do_write && !illegal;
    end

    // Select the addressed counter.
    always_comb begin
        sel_cnt = '0;
        for (int i = 0; i < NUM_CNT; i++) begin
            if (slot == 4'(i))
                sel_cnt = cnt_val[i];
        end
        sel_ext = 64'(sel_cnt);
    end

    // Old-value read mux and RW/RS/RC write value.
    always_comb begin
        raw = '0;
        if (cnt_ok)
            raw = cnt_hi ? sel_ext[63:32] : sel_ext[31:0];
        else if (is_fp && csrAddr_i == ADDR_FFLAGS)
            raw = {27'd0, fcsr[FFLAGS_MSB:FFLAGS_LSB]};
        else if (is_fp && csrAddr_i == ADDR_FRM)
            raw = {29'd0, fcsr[FRM_MSB:FRM_LSB]};
        else if (is_fp)
            raw = {24'd0, fcsr};
        else if (is_inh)
            raw = inhibit;

        case (op)
            OP_RS:   wval = raw | csrSrc_i;
            OP_RC:   wval = raw & ~csrSrc_i;
            default: wval = csrSrc_i;
        endcase
    end

    assign csrRData_o   = illegal ? 32'd0 : raw;
    assign csrIllegal_o = illegal;

    // Per-counter increment and write strobes.
    always_comb begin
        cnt_inc   = '0;
        cnt_wr_lo = '0;
        cnt_wr_hi = '0;
        cnt_inc[0] = !inhibit[INH_CY];
        cnt_inc[1] = csrInstStep_i && !inhibit[INH_IR];
        for (int k = 0; k < NUM_HPM; k++)
            cnt_inc[2+k] = hpmEvent_i[k] && !inhibit[INH_HPM0+k];
        for (int i = 0; i < NUM_CNT; i++) begin
            if (wr_en && cnt_ok && cnt_mpage && slot == 4'(i)) begin
                cnt_wr_lo[i] = !cnt_hi;
                cnt_wr_hi[i] = cnt_hi;
            end
        end
    end

    for (genvar g = 0; g < NUM_CNT; g++) begin : g_cnt
        csr_counter #(.W(COUNTER_W)) u_cnt (
            .clk   (clk_i),
            .reset (reset_i),
            .inc   (cnt_inc[g]),
            .wrLo  (cnt_wr_lo[g]),
            .wrHi  (cnt_wr_hi[g]),
            .wdata (wval),
            .value (cnt_val[g])
        );
    end

    // mcountinhibit keeps only its implemented bits.
    always_ff @(posedge clk_i) begin
        if (reset_i)
            inhibit <= '0;
        else if (wr_en && is_inh)
            inhibit <= wval & INH_MASK;
    end

    // fcsr next value: field-scoped write first, then flag accrual on top.
    always_comb begin
        fcsr_next = fcsr;
        if (wr_en && fp_ok) begin
            if (csrAddr_i == ADDR_FFLAGS)
                fcsr_next[FFLAGS_MSB:FFLAGS_LSB] = wval[4:0];
            else if (csrAddr_i == ADDR_FRM)
                fcsr_next[FRM_MSB:FRM_LSB] = wval[2:0];
            else
                fcsr_next = wval[7:0];
        end
        if (fflagsValid_i)
            fcsr_next[FFLAGS_MSB:FFLAGS_LSB] = fcsr_next[FFLAGS_MSB:FFLAGS_LSB] | fflags_i;
    end

    // fcsr register.
    always_ff @(posedge clk_i) begin
        if (reset_i)
            fcsr <= '0;
        else
            fcsr <= fcsr_next;
    end

    assign csrFRM_o = fcsr[FRM_MSB:FRM_LSB];

endmodule

// File: tb/tb_csr_unit.sv
// Directed bench for csr_unit: a vector table for single-cycle accesses plus
// hand-written sequences for counter carry, inhibit, accrual and reset.
module tb_csr_unit;

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic        csrValid_i;
    logic [1:0]  csrOp_i;
    logic [11:0] csrAddr_i;
    logic [31:0] csrSrc_i;
    logic [31:0] csrRData_o;
    logic        csrIllegal_o;
    logic        csrInstStep_i;
    logic        fflagsValid_i;
    logic [4:0]  fflags_i;
    logic [3:0]  hpmEvent_i;
    logic [2:0]  csrFRM_o;
    logic [31:0] nf_rdata;
    logic        nf_illegal;
    logic [2:0]  nf_frm;

    int checks = 0;
    int errors = 0;

    localparam logic [1:0] RW = 2'b01, RS = 2'b10, RC = 2'b11;

    typedef struct {
        logic        valid;
        logic [1:0]  op;
        logic [11:0] addr;
        logic [31:0] src;
        logic        chk_rd;
        logic [31:0] exp_rd;
        logic        exp_ill;
    } vec_t;

    vec_t vecs [20];

    csr_unit dut (
        .clk_i         (clk_i),
        .reset_i       (reset_i),
        .csrValid_i    (csrValid_i),
        .csrOp_i       (csrOp_i),
        .csrAddr_i     (csrAddr_i),
        .csrSrc_i      (csrSrc_i),
        .csrRData_o    (csrRData_o),
        .csrIllegal_o  (csrIllegal_o),
        .csrInstStep_i (csrInstStep_i),
        .fflagsValid_i (fflagsValid_i),
        .fflags_i      (fflags_i),
        .hpmEvent_i    (hpmEvent_i),
        .csrFRM_o      (csrFRM_o)
    );

    csr_unit #(.NUM_HPM(4), .COUNTER_W(40), .HAS_FPU(0)) dut_nf (
        .clk_i         (clk_i),
        .reset_i       (reset_i),
        .csrValid_i    (csrValid_i),
        .csrOp_i       (csrOp_i),
        .csrAddr_i     (csrAddr_i),
        .csrSrc_i      (csrSrc_i),
        .csrRData_o    (nf_rdata),
        .csrIllegal_o  (nf_illegal),
        .csrInstStep_i (csrInstStep_i),
        .fflagsValid_i (fflagsValid_i),
        .fflags_i      (fflags_i),
        .hpmEvent_i    (hpmEvent_i),
        .csrFRM_o      (nf_frm)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drv(input logic [1:0] op, input logic [11:0] a, input logic [31:0] s);
        csrValid_i = 1'b1;
        csrOp_i    = op;
        csrAddr_i  = a;
        csrSrc_i   = s;
    endtask

    task automatic idle();
        csrValid_i = 1'b0;
        csrOp_i    = 2'b00;
        csrAddr_i  = 12'h000;
        csrSrc_i   = 32'd0;
    endtask

    task automatic rd_chk(input string name, input logic [11:0] a, input logic [31:0] exp);
        drv(RS, a, 32'd0);
        #1;
        check(name, csrRData_o, exp);
    endtask

    task automatic do_reset();
        reset_i = 1'b1;
        idle();
        tick();
        tick();
        reset_i = 1'b0;
    endtask

    initial begin
        vecs[0]  = '{1'b1, RW, 12'h002, 32'h0000_0005, 1'b1, 32'h0000_0000, 1'b0};
        vecs[1]  = '{1'b1, RS, 12'h001, 32'h0000_0003, 1'b1, 32'h0000_0000, 1'b0};
        vecs[2]  = '{1'b1, RC, 12'h003, 32'h0000_0001, 1'b1, 32'h0000_00A3, 1'b0};
        vecs[3]  = '{1'b1, RS, 12'h003, 32'h0000_0000, 1'b1, 32'h0000_00A2, 1'b0};
        vecs[4]  = '{1'b1, RW, 12'h001, 32'h0000_00FF, 1'b1, 32'h0000_0002, 1'b0};
        vecs[5]  = '{1'b1, RS, 12'h002, 32'h0000_0000, 1'b1, 32'h0000_0005, 1'b0};
        vecs[6]  = '{1'b1, RS, 12'h003, 32'h0000_0000, 1'b1, 32'h0000_00BF, 1'b0};
        vecs[7]  = '{1'b1, RW, 12'h320, 32'hFFFF_FFFF, 1'b1, 32'h0000_0000, 1'b0};
        vecs[8]  = '{1'b1, RS, 12'h320, 32'h0000_0000, 1'b1, 32'h0000_007D, 1'b0};
        vecs[9]  = '{1'b1, RW, 12'h320, 32'h0000_0000, 1'b1, 32'h0000_007D, 1'b0};
        vecs[10] = '{1'b1, RS, 12'h320, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b0};
        vecs[11] = '{1'b1, RW, 12'hC00, 32'h0000_0001, 1'b1, 32'h0000_0000, 1'b1};
        vecs[12] = '{1'b1, RS, 12'hC00, 32'h0000_0000, 1'b0, 32'h0000_0000, 1'b0};
        vecs[13] = '{1'b1, RS, 12'hB07, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b1};
        vecs[14] = '{1'b1, RS, 12'hB01, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b1};
        vecs[15] = '{1'b1, RS, 12'h7FF, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b1};
        vecs[16] = '{1'b1, RS, 12'hC83, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b0};
        vecs[17] = '{1'b1, RC, 12'hC02, 32'h0000_0004, 1'b1, 32'h0000_0000, 1'b1};
        vecs[18] = '{1'b0, RW, 12'hC00, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b0};
        vecs[19] = '{1'b1, RS, 12'hB86, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b0};

        csrInstStep_i = 1'b0;
        fflagsValid_i = 1'b0;
        fflags_i      = 5'd0;
        hpmEvent_i    = 4'd0;
        do_reset();

        // Ten idle clocks after reset.
        repeat (10) tick();
        rd_chk("cycle after 10 clocks", 12'hC00, 32'd10);
        rd_chk("cycleh after reset", 12'hC80, 32'd0);
        check("frm after reset", 32'(csrFRM_o), 32'd0);
        tick();

        // Vector table.
        for (int i = 0; i < 20; i++) begin
            drv(vecs[i].op, vecs[i].addr, vecs[i].src);
            csrValid_i = vecs[i].valid;
            #1;
            if (vecs[i].chk_rd)
                check($sformatf("vec%0d rdata", i), csrRData_o, vecs[i].exp_rd);
            check($sformatf("vec%0d illegal", i), 32'(csrIllegal_o), 32'(vecs[i].exp_ill));
            tick();
        end
        idle();
        check("frm after table", 32'(csrFRM_o), 32'd5);

        // Low half wraps into the high half one cycle after the high write.
        drv(RW, 12'hB00, 32'hFFFF_FFFF);
        tick();
        drv(RW, 12'hB80, 32'h0000_0000);
        tick();
        idle();
        tick();
        rd_chk("mcycle lo after carry", 12'hB00, 32'h0000_0000);
        rd_chk("mcycle hi after carry", 12'hB80, 32'h0000_0001);
        tick();

        // Full 64-bit wrap of minstret.
        drv(RW, 12'hB02, 32'hFFFF_FFFF);
        tick();
        drv(RW, 12'hB82, 32'hFFFF_FFFF);
        tick();
        rd_chk("minstreth loaded", 12'hB82, 32'hFFFF_FFFF);
        idle();
        csrInstStep_i = 1'b1;
        tick();
        csrInstStep_i = 1'b0;
        rd_chk("minstret lo wrapped", 12'hB02, 32'h0);
        rd_chk("minstret hi wrapped", 12'hB82, 32'h0);
        tick();

        // Inhibit the cycle counter while instret keeps counting.
        drv(RW, 12'hB02, 32'd0);
        tick();
        drv(RW, 12'hB00, 32'd100);
        tick();
        drv(RS, 12'h320, 32'h1);
        tick();
        idle();
        for (int i = 0; i < 5; i++) begin
            csrInstStep_i = (i % 2 == 0);
            tick();
        end
        csrInstStep_i = 1'b0;
        rd_chk("cycle frozen", 12'hC00, 32'd101);
        rd_chk("instret counts while cycle inhibited", 12'hC02, 32'd3);
        drv(RC, 12'h320, 32'h1);
        tick();
        idle();
        tick();
        tick();
        rd_chk("cycle resumed", 12'hC00, 32'd103);
        tick();

        // Illegal write to the read-only shadow leaves the counter counting normally.
        drv(RW, 12'hB00, 32'd50);
        tick();
        drv(RW, 12'hC00, 32'h0000_1234);
        #1;
        check("RW cycle illegal", 32'(csrIllegal_o), 32'd1);
        check("RW cycle rdata zero", csrRData_o, 32'd0);
        tick();
        rd_chk("cycle after illegal write", 12'hC00, 32'd51);
        tick();

        // Flag accrual and write/accrual collision.
        drv(RW, 12'h003, 32'd0);
        tick();
        idle();
        fflagsValid_i = 1'b1;
        fflags_i      = 5'h04;
        tick();
        fflags_i      = 5'h01;
        tick();
        fflagsValid_i = 1'b0;
        rd_chk("fflags accrued", 12'h001, 32'h05);
        tick();
        drv(RW, 12'h003, 32'hA0);
        fflagsValid_i = 1'b1;
        fflags_i      = 5'h02;
        #1;
        check("frm before fcsr edge", 32'(csrFRM_o), 32'd0);
        tick();
        fflagsValid_i = 1'b0;
        fflags_i      = 5'd0;
        rd_chk("fcsr write plus accrual", 12'h003, 32'hA2);
        check("frm after fcsr write", 32'(csrFRM_o), 32'd5);
        tick();

        // Instance without FPU and with 40-bit counters.
        drv(RS, 12'h003, 32'd0);
        #1;
        check("nofpu fcsr illegal", 32'(nf_illegal), 32'd1);
        check("nofpu fcsr rdata", nf_rdata, 32'd0);
        check("fpu fcsr legal", 32'(csrIllegal_o), 32'd0);
        drv(RW, 12'h001, 32'd1);
        #1;
        check("nofpu fflags illegal", 32'(nf_illegal), 32'd1);
        drv(RW, 12'hB80, 32'hFFFF_FFFF);
        #1;
        check("nofpu mcycleh legal", 32'(nf_illegal), 32'd0);
        tick();
        drv(RS, 12'hB80, 32'd0);
        #1;
        check("nofpu mcycleh truncated", nf_rdata, 32'h0000_00FF);
        tick();

        // hpm event routing, then reset in the middle of counting.
        idle();
        hpmEvent_i = 4'b0010;
        repeat (3) tick();
        hpmEvent_i = 4'b0000;
        rd_chk("hpm4 counted", 12'hB04, 32'd3);
        rd_chk("hpm3 untouched", 12'hB03, 32'd0);
        rd_chk("hpm4 high", 12'hC84, 32'd0);
        tick();
        hpmEvent_i    = 4'b1111;
        csrInstStep_i = 1'b1;
        drv(RW, 12'hB00, 32'd7);
        reset_i = 1'b1;
        tick();
        reset_i       = 1'b0;
        hpmEvent_i    = 4'b0000;
        csrInstStep_i = 1'b0;
        rd_chk("cycle after reset", 12'hB00, 32'd0);
        rd_chk("instret after reset", 12'hB02, 32'd0);
        rd_chk("hpm4 after reset", 12'hB04, 32'd0);
        rd_chk("fcsr after reset", 12'h003, 32'd0);
        check("frm after mid reset", 32'(csrFRM_o), 32'd0);
        tick();
        idle();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
